// File: rtl/rv_wb_pkg.sv
// Shared types and sizes for the register-file write-back path.
package rv_wb_pkg;
    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] dr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_e;
endpackage

// File: rtl/writeback_unit_if.sv
// Execute/memory/decode-facing signals of writeback_unit; WB_BYPASS_EN adds forwarding taps.
interface writeback_unit_if;
    import rv_wb_pkg::*;

    logic                  ALU_V;
    logic [REG_ADDR_W-1:0] ALU_DR;
    logic [XLEN-1:0]       ALU_DATA;
    logic                  MEM_V;
    logic [REG_ADDR_W-1:0] MEM_DR;
    logic [XLEN-1:0]       MEM_DATA;
    // MEM_V/MEM_RDY: a result transfers on a cycle where both are 1; MEM_V holds until then. ALU_V has no ready.
    logic                  MEM_RDY;
    logic                  ISSUE_V;
    logic [REG_ADDR_W-1:0] ISSUE_DR;
    logic [REG_ADDR_W-1:0] DR;
    logic [XLEN-1:0]       WB_DATA;
    logic                  ST_REG;
    logic [NREG-1:0]       BUSY;
`ifdef WB_BYPASS_EN
    logic [REG_ADDR_W-1:0] SR1;
    logic [REG_ADDR_W-1:0] SR2;
    logic                  FWD1_V;
    logic                  FWD2_V;
    logic [XLEN-1:0]       FWD1_DATA;
    logic [XLEN-1:0]       FWD2_DATA;
`endif

    modport master (
        output ALU_V, ALU_DR, ALU_DATA, MEM_V, MEM_DR, MEM_DATA, ISSUE_V, ISSUE_DR,
        input  MEM_RDY, DR, WB_DATA, ST_REG, BUSY
`ifdef WB_BYPASS_EN
        , output SR1, SR2,
        input  FWD1_V, FWD2_V, FWD1_DATA, FWD2_DATA
`endif
    );

    modport slave (
        input  ALU_V, ALU_DR, ALU_DATA, MEM_V, MEM_DR, MEM_DATA, ISSUE_V, ISSUE_DR,
        output MEM_RDY, DR, WB_DATA, ST_REG, BUSY
`ifdef WB_BYPASS_EN
        , input SR1, SR2,
        output FWD1_V, FWD2_V, FWD1_DATA, FWD2_DATA
`endif
    );
endinterface

// File: rtl/wb_mem_fifo.sv
// Memory-result queue: count-based occupancy FSM, registered ready output.
module wb_mem_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    CLK,
    input  logic    reset_n,
    input  logic    enq,
    input  wb_req_t wr_req,
    input  logic    deq,
    output wb_req_t head,
    output logic    empty,
    output logic    rdy,
    output occ_e    occ
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    occ_e          occ_next;

    always_comb begin
        count_next = count;
        if (enq && !deq)
            count_next = count + CW'(1);
        else if (deq && !enq)
            count_next = count - CW'(1);
        if (count_next == '0)
            occ_next = OCC_EMPTY;
        else if (count_next == CW'(DEPTH))
            occ_next = OCC_FULL;
        else
            occ_next = OCC_PARTIAL;
    end

    // rdy resets low and rises on the first edge after release.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            occ    <= OCC_EMPTY;
            rdy    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_next;
            occ   <= occ_next;
            rdy   <= (occ_next != OCC_FULL);
            if (enq)
                wr_ptr <= wr_ptr + PW'(1);
            if (deq)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (enq)
            mem[wr_ptr] <= wr_req;
    end

    assign head  = mem[rd_ptr];
    assign empty = (occ == OCC_EMPTY);
endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port arbiter (ALU > queued MEM > direct MEM) with pending-write scoreboard.
// Optional WB_BYPASS_EN adds combinational forwarding of the in-flight write.
module writeback_unit
    import rv_wb_pkg::*;
#(
    parameter int MEMQ_DEPTH = 2
) (
    input  logic             CLK,
    input  logic             reset_n,
    writeback_unit_if.slave  wb,
    output occ_e             dbg_occ
);
    wb_req_t               head, sel, mem_req;
    logic                  q_empty, q_rdy, mem_acc, enq, deq;
    logic [REG_ADDR_W-1:0] dr_q;
    logic [XLEN-1:0]       data_q;
    logic                  st_q;
    logic [NREG-1:0]       busy_q, busy_next;

    assign mem_acc = wb.MEM_V && q_rdy;
    assign mem_req = {1'b1, wb.MEM_DR, wb.MEM_DATA};

    always_comb begin
        sel = '0;
        deq = 1'b0;
        if (wb.ALU_V)
            sel = {1'b1, wb.ALU_DR, wb.ALU_DATA};
        else if (!q_empty) begin
            sel = head;
            deq = 1'b1;
        end else if (mem_acc)
            sel = mem_req;
        // Anything accepted that could not take the port this cycle waits in the queue.
        enq = mem_acc && (wb.ALU_V || !q_empty);
    end

    wb_mem_fifo #(.DEPTH(MEMQ_DEPTH)) u_fifo (
        .CLK     (CLK),
        .reset_n (reset_n),
        .enq     (enq),
        .wr_req  (mem_req),
        .deq     (deq),
        .head    (head),
        .empty   (q_empty),
        .rdy     (q_rdy),
        .occ     (dbg_occ)
    );

    // Writes to r0 still consume the slot but never strobe the register file.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            dr_q   <= '0;
            data_q <= '0;
            st_q   <= 1'b0;
        end else if (sel.v) begin
            dr_q   <= sel.dr;
            data_q <= sel.data;
            st_q   <= (sel.dr != '0);
        end else begin
            st_q   <= 1'b0;
        end
    end

    always_comb begin
        busy_next = busy_q;
        if (st_q)
            busy_next[dr_q] = 1'b0;
        if (wb.ISSUE_V && wb.ISSUE_DR != '0)
            busy_next[wb.ISSUE_DR] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n)
            busy_q <= '0;
        else
            busy_q <= busy_next;
    end

    assign wb.MEM_RDY = q_rdy;
    assign wb.DR      = dr_q;
    assign wb.WB_DATA = data_q;
    assign wb.ST_REG  = st_q;
    assign wb.BUSY    = busy_q;

`ifdef WB_BYPASS_EN
    assign wb.FWD1_V    = st_q && (dr_q == wb.SR1) && (wb.SR1 != '0);
    assign wb.FWD2_V    = st_q && (dr_q == wb.SR2) && (wb.SR2 != '0);
    assign wb.FWD1_DATA = data_q;
    assign wb.FWD2_DATA = data_q;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic vs a queue-based model.
module tb_writeback_unit;
    import rv_wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int QW    = REG_ADDR_W + XLEN;

    logic CLK = 1'b0;
    logic reset_n = 1'b0;
    always #5 CLK = ~CLK;

    writeback_unit_if bus ();
    occ_e dbg_occ;

    writeback_unit #(.MEMQ_DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .wb      (bus),
        .dbg_occ (dbg_occ)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: waiting memory results in arrival order, plus visible output state.
    logic [QW-1:0]   exp_q [$];
    logic            m_rdy, m_st;
    logic [4:0]      m_dr;
    logic [XLEN-1:0] m_data;
    logic [NREG-1:0] m_busy;

    task automatic set_idle();
        bus.ALU_V = 0; bus.ALU_DR = 0; bus.ALU_DATA = 0;
        bus.MEM_V = 0; bus.MEM_DR = 0; bus.MEM_DATA = 0;
        bus.ISSUE_V = 0; bus.ISSUE_DR = 0;
`ifdef WB_BYPASS_EN
        bus.SR1 = 0; bus.SR2 = 0;
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_rdy = 0; m_st = 0; m_dr = 0; m_data = 0; m_busy = 0;
    endtask

    // Advance one clock: update the model from the current inputs, then sample #1 after the edge.
    task automatic tick();
        logic            acc, have;
        logic [QW-1:0]   w;
        logic [NREG-1:0] nb;
        acc = bus.MEM_V && m_rdy;
        have = 0;
        w = '0;
        if (bus.ALU_V) begin
            have = 1; w = {bus.ALU_DR, bus.ALU_DATA};
        end else if (exp_q.size() > 0) begin
            have = 1; w = exp_q.pop_front();
        end else if (acc) begin
            have = 1; w = {bus.MEM_DR, bus.MEM_DATA}; acc = 0;
        end
        if (acc) exp_q.push_back({bus.MEM_DR, bus.MEM_DATA});
        nb = m_busy;
        if (m_st) nb[m_dr] = 1'b0;
        if (bus.ISSUE_V && bus.ISSUE_DR != 0) nb[bus.ISSUE_DR] = 1'b1;
        m_busy = nb;
        if (have) begin
            m_dr = w[QW-1:XLEN]; m_data = w[XLEN-1:0]; m_st = (m_dr != 0);
        end else begin
            m_st = 0;
        end
        m_rdy = (exp_q.size() < DEPTH);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        model_reset();
        reset_n = 0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (bus.ST_REG !== 1'b0) begin failures++; $display("FAIL rst_st: got %0b want 0", bus.ST_REG); end
        checks++; if (bus.DR !== 5'd0) begin failures++; $display("FAIL rst_dr: got %0d want 0", bus.DR); end
        checks++; if (bus.WB_DATA !== 64'd0) begin failures++; $display("FAIL rst_data: got %h want 0", bus.WB_DATA); end
        checks++; if (bus.BUSY !== 32'd0) begin failures++; $display("FAIL rst_busy: got %h want 0", bus.BUSY); end
        checks++; if (bus.MEM_RDY !== 1'b0) begin failures++; $display("FAIL rst_rdy: got %0b want 0", bus.MEM_RDY); end
        reset_n = 1;
        tick();
        checks++; if (bus.MEM_RDY !== 1'b1) begin failures++; $display("FAIL rst_rdy_release: got %0b want 1", bus.MEM_RDY); end
    endtask

    task automatic test_alu();
        set_idle();
        bus.ISSUE_V = 1; bus.ISSUE_DR = 5;
        tick();
        checks++; if (bus.BUSY[5] !== 1'b1) begin failures++; $display("FAIL alu_busy_set: got %0b want 1", bus.BUSY[5]); end
        set_idle();
        bus.ALU_V = 1; bus.ALU_DR = 5; bus.ALU_DATA = 64'hDEAD;
        tick();
        checks++; if (bus.ST_REG !== 1'b1) begin failures++; $display("FAIL alu_st: got %0b want 1", bus.ST_REG); end
        checks++; if (bus.DR !== 5'd5) begin failures++; $display("FAIL alu_dr: got %0d want 5", bus.DR); end
        checks++; if (bus.WB_DATA !== 64'hDEAD) begin failures++; $display("FAIL alu_data: got %h want dead", bus.WB_DATA); end
        checks++; if (bus.BUSY[5] !== 1'b1) begin failures++; $display("FAIL alu_busy_hold: got %0b want 1", bus.BUSY[5]); end
        set_idle();
        tick();
        checks++; if (bus.ST_REG !== 1'b0) begin failures++; $display("FAIL alu_idle_st: got %0b want 0", bus.ST_REG); end
        checks++; if (bus.DR !== 5'd5 || bus.WB_DATA !== 64'hDEAD) begin failures++; $display("FAIL alu_idle_hold: got %0d/%h want 5/dead", bus.DR, bus.WB_DATA); end
        checks++; if (bus.BUSY[5] !== 1'b0) begin failures++; $display("FAIL alu_busy_clr: got %0b want 0", bus.BUSY[5]); end
    endtask

    task automatic test_alu_mem_same_cycle();
        set_idle();
        bus.ALU_V = 1; bus.ALU_DR = 3; bus.ALU_DATA = 64'h33;
        bus.MEM_V = 1; bus.MEM_DR = 7; bus.MEM_DATA = 64'h77;
        tick();
        checks++; if (bus.ST_REG !== 1'b1 || bus.DR !== 5'd3 || bus.WB_DATA !== 64'h33) begin failures++; $display("FAIL same_alu: got %0b/%0d/%h want 1/3/33", bus.ST_REG, bus.DR, bus.WB_DATA); end
        set_idle();
        tick();
        checks++; if (bus.ST_REG !== 1'b1 || bus.DR !== 5'd7 || bus.WB_DATA !== 64'h77) begin failures++; $display("FAIL same_mem: got %0b/%0d/%h want 1/7/77", bus.ST_REG, bus.DR, bus.WB_DATA); end
        tick();
        checks++; if (bus.ST_REG !== 1'b0) begin failures++; $display("FAIL same_drain: got %0b want 0", bus.ST_REG); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        set_idle();
        bus.MEM_V = 1; bus.MEM_DR = 10; bus.MEM_DATA = 64'h100;
        for (int i = 0; i < 4; i++) begin
            bus.ALU_V = 1; bus.ALU_DR = 5'(20 + i); bus.ALU_DATA = 64'(i);
            #1;
            checks++; if (bus.MEM_RDY !== (i < 2)) begin failures++; $display("FAIL b2b_rdy%0d: got %0b want %0b", i, bus.MEM_RDY, (i < 2)); end
            acc = m_rdy;
            tick();
            checks++; if (bus.ST_REG !== 1'b1 || bus.DR !== 5'(20 + i)) begin failures++; $display("FAIL b2b_alu%0d: got %0b/%0d want 1/%0d", i, bus.ST_REG, bus.DR, 20 + i); end
            if (acc) begin
                bus.MEM_DR = bus.MEM_DR + 1; bus.MEM_DATA = bus.MEM_DATA + 1;
            end
        end
        set_idle();
        tick();
        checks++; if (bus.ST_REG !== 1'b1 || bus.DR !== 5'd10 || bus.WB_DATA !== 64'h100) begin failures++; $display("FAIL b2b_q0: got %0b/%0d/%h want 1/10/100", bus.ST_REG, bus.DR, bus.WB_DATA); end
        tick();
        checks++; if (bus.ST_REG !== 1'b1 || bus.DR !== 5'd11 || bus.WB_DATA !== 64'h101) begin failures++; $display("FAIL b2b_q1: got %0b/%0d/%h want 1/11/101", bus.ST_REG, bus.DR, bus.WB_DATA); end
        tick();
        checks++; if (bus.ST_REG !== 1'b0) begin failures++; $display("FAIL b2b_drain: got %0b want 0", bus.ST_REG); end
    endtask

    task automatic test_dest_zero();
        set_idle();
        bus.ALU_V = 1; bus.ALU_DR = 0; bus.ALU_DATA = 64'hFF;
        bus.ISSUE_V = 1; bus.ISSUE_DR = 0;
        tick();
        checks++; if (bus.ST_REG !== 1'b0) begin failures++; $display("FAIL dz_st: got %0b want 0", bus.ST_REG); end
        checks++; if (bus.BUSY !== 32'd0) begin failures++; $display("FAIL dz_busy: got %h want 0", bus.BUSY); end
        set_idle();
        tick();
    endtask

    task automatic test_set_clear_same_edge();
        set_idle();
        bus.ISSUE_V = 1; bus.ISSUE_DR = 9;
        tick();
        set_idle();
        bus.ALU_V = 1; bus.ALU_DR = 9; bus.ALU_DATA = 64'h99;
        tick();
        checks++; if (bus.ST_REG !== 1'b1 || bus.DR !== 5'd9) begin failures++; $display("FAIL sc_commit: got %0b/%0d want 1/9", bus.ST_REG, bus.DR); end
        set_idle();
        bus.ISSUE_V = 1; bus.ISSUE_DR = 9;
        tick();
        checks++; if (bus.BUSY[9] !== 1'b1) begin failures++; $display("FAIL sc_set_wins: got %0b want 1", bus.BUSY[9]); end
        set_idle();
        tick();
        checks++; if (bus.BUSY[9] !== 1'b1) begin failures++; $display("FAIL sc_stays: got %0b want 1", bus.BUSY[9]); end
    endtask

    task automatic test_bypass();
`ifdef WB_BYPASS_EN
        set_idle();
        bus.ALU_V = 1; bus.ALU_DR = 12; bus.ALU_DATA = 64'hC0FFEE;
        tick();
        bus.ALU_V = 0; bus.SR1 = 12; bus.SR2 = 13;
        #1;
        checks++; if (bus.FWD1_V !== 1'b1 || bus.FWD1_DATA !== 64'hC0FFEE) begin failures++; $display("FAIL byp_fwd1: got %0b/%h want 1/c0ffee", bus.FWD1_V, bus.FWD1_DATA); end
        checks++; if (bus.FWD2_V !== 1'b0) begin failures++; $display("FAIL byp_fwd2: got %0b want 0", bus.FWD2_V); end
        set_idle();
        tick();
`endif
    endtask

    task automatic test_random();
        set_idle();
        for (int n = 0; n < 400; n++) begin
            bus.ALU_V = ($urandom_range(0, 9) < 4);
            bus.ALU_DR = 5'($urandom_range(0, 31));
            bus.ALU_DATA = {$urandom, $urandom};
            bus.MEM_V = 1'($urandom_range(0, 1));
            bus.MEM_DR = 5'($urandom_range(0, 31));
            bus.MEM_DATA = {$urandom, $urandom};
            bus.ISSUE_V = 1'($urandom_range(0, 1));
            bus.ISSUE_DR = 5'($urandom_range(0, 31));
            #1;
            checks++; if (bus.MEM_RDY !== m_rdy) begin failures++; $display("FAIL rnd_rdy@%0d: got %0b want %0b", n, bus.MEM_RDY, m_rdy); end
            tick();
            checks++; if (bus.ST_REG !== m_st) begin failures++; $display("FAIL rnd_st@%0d: got %0b want %0b", n, bus.ST_REG, m_st); end
            if (m_st) begin
                checks++; if (bus.DR !== m_dr || bus.WB_DATA !== m_data) begin failures++; $display("FAIL rnd_wr@%0d: got %0d/%h want %0d/%h", n, bus.DR, bus.WB_DATA, m_dr, m_data); end
            end
            checks++; if (bus.BUSY !== m_busy) begin failures++; $display("FAIL rnd_busy@%0d: got %h want %h", n, bus.BUSY, m_busy); end
        end
        set_idle();
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset_mid_queue();
        set_idle();
        bus.ALU_V = 1; bus.ALU_DR = 1; bus.ALU_DATA = 64'h1;
        bus.MEM_V = 1; bus.MEM_DR = 2; bus.MEM_DATA = 64'h22;
        bus.ISSUE_V = 1; bus.ISSUE_DR = 4;
        tick();
        checks++; if (dbg_occ !== OCC_PARTIAL) begin failures++; $display("FAIL mid_occ_one: got %0d want %0d", dbg_occ, OCC_PARTIAL); end
        set_idle();
        #2;
        reset_n = 0;
        #1;
        checks++; if (bus.ST_REG !== 1'b0 || bus.DR !== 5'd0 || bus.WB_DATA !== 64'd0) begin failures++; $display("FAIL mid_out: got %0b/%0d/%h want 0/0/0", bus.ST_REG, bus.DR, bus.WB_DATA); end
        checks++; if (bus.BUSY !== 32'd0 || bus.MEM_RDY !== 1'b0) begin failures++; $display("FAIL mid_busy_rdy: got %h/%0b want 0/0", bus.BUSY, bus.MEM_RDY); end
        model_reset();
        @(posedge CLK);
        #1;
        reset_n = 1;
        tick();
        checks++; if (bus.ST_REG !== 1'b0) begin failures++; $display("FAIL mid_stale: got %0b want 0", bus.ST_REG); end
        checks++; if (bus.MEM_RDY !== 1'b1) begin failures++; $display("FAIL mid_rdy: got %0b want 1", bus.MEM_RDY); end
        tick();
        checks++; if (bus.ST_REG !== 1'b0 || dbg_occ !== OCC_EMPTY) begin failures++; $display("FAIL mid_empty: got %0b/%0d want 0/%0d", bus.ST_REG, dbg_occ, OCC_EMPTY); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_alu_mem_same_cycle();
        test_back_to_back();
        test_dest_zero();
        test_set_clear_same_edge();
        test_bypass();
        test_random();
        test_reset_mid_queue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
